// File: rtl/data_sync_launch_pkg.sv
// Shared definitions for the source-side launch block of the multi-bit CDC path:
// FSM state encoding and the synchroniser depth default with its legal range.
package data_sync_launch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LAUNCH   = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   localparam int NUM_STAGES_DEFAULT = 2;
   localparam int NUM_STAGES_MIN     = 2;
   localparam int NUM_STAGES_MAX     = 4;

   function automatic bit num_stages_legal(input int n);
      return (n >= NUM_STAGES_MIN) && (n <= NUM_STAGES_MAX);
   endfunction

   // Out-of-range depths fall back to the default rather than building a broken chain.
   function automatic int num_stages_checked(input int n);
      return num_stages_legal(n) ? n : NUM_STAGES_DEFAULT;
   endfunction

endpackage

// File: rtl/data_sync_launch_if.sv
// Source handshake plus the held bus / req / ack toggle wires crossing to the destination.
interface data_sync_launch_if #(
   parameter int BUS_WIDTH = 8
);
   logic [BUS_WIDTH-1:0] src_data;
   logic                 src_valid;
   logic                 src_ready;
   logic                 ack_toggle;
   logic [BUS_WIDTH-1:0] tx_bus;
   logic                 tx_req;

   modport master (
      input  src_data,
      input  src_valid,
      input  ack_toggle,
      output src_ready,
      output tx_bus,
      output tx_req
   );

   modport slave (
      output src_data,
      output src_valid,
      output ack_toggle,
      input  src_ready,
      input  tx_bus,
      input  tx_req
   );
endinterface

// File: rtl/data_sync_launch_bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset; also used
// for the req toggle on the destination side.
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_reg;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge CLK or negedge RST) begin
               if (!RST) sync_reg[gi] <= 1'b0;
               else      sync_reg[gi] <= d;
            end
         end else begin : g_chain
            always_ff @(posedge CLK or negedge RST) begin
               if (!RST) sync_reg[gi] <= 1'b0;
               else      sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/data_sync_launch.sv
// Source-domain launcher: captures a word, holds it on tx_bus, flips tx_req one cycle
// later, then waits for the synchronised ack toggle to match before accepting again.
module data_sync_launch
   import data_sync_launch_pkg::*;
#(
   parameter int BUS_WIDTH  = 8,
   parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   data_sync_launch_if.master   link,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] xfer_count
);
   localparam int SYNC_STAGES = num_stages_checked(NUM_STAGES);

   state_t               state_reg, state_next;
   logic [BUS_WIDTH-1:0] bus_reg, bus_next;
   logic                 req_reg, req_next;
   logic [CNT_WIDTH-1:0] count_reg, count_next;
   logic                 ack_sync;

   bit_sync #(
      .STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (link.ack_toggle),
      .q   (ack_sync)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg <= IDLE;
         bus_reg   <= '0;
         req_reg   <= 1'b0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         bus_reg   <= bus_next;
         req_reg   <= req_next;
         count_reg <= count_next;
      end
   end

   // The bus is loaded on the accept edge and req flips a cycle later, so the
   // destination never sees a req edge before the data has settled.
   always_comb begin
      state_next = state_reg;
      bus_next   = bus_reg;
      req_next   = req_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (link.src_valid) begin
               state_next = LAUNCH;
               bus_next   = link.src_data;
            end
         end
         LAUNCH: begin
            req_next   = ~req_reg;
            state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack_sync == req_reg) begin
               state_next = IDLE;
               count_next = count_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign link.src_ready = (state_reg == IDLE);
   assign link.tx_bus    = bus_reg;
   assign link.tx_req    = req_reg;
   assign busy           = (state_reg != IDLE);
   assign xfer_count     = count_reg;
endmodule

// File: tb/tb_data_sync_launch.sv
// Randomised bench for data_sync_launch: a small parity/latency/count model predicts
// every output, with a destination model that toggles ack after a random delay.
module tb_data_sync_launch;
   localparam int BW = 8;
   localparam int NS = 2;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_sync_launch_if #(.BUS_WIDTH(BW)) link();
   logic          busy;
   logic [CW-1:0] xfer_count;

   data_sync_launch #(
      .BUS_WIDTH  (BW),
      .NUM_STAGES (NS),
      .CNT_WIDTH  (CW)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .link       (link),
      .busy       (busy),
      .xfer_count (xfer_count)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: expected req level, ack level driven, completed count.
   logic          model_req = 1'b0;
   logic          model_ack = 1'b0;
   logic [CW-1:0] model_count = '0;
   logic [BW-1:0] model_bus = '0;

   logic [BW-1:0] prev_bus = '0;
   logic          prev_busy = 1'b0;

   // The held word must not move while a transfer is outstanding.
   always @(negedge clk) begin
      if (!rst) begin
         prev_busy = 1'b0;
      end else begin
         if (prev_busy && busy) begin
            vectors++;
            if (link.tx_bus !== prev_bus) begin
               miscompares++;
               $display("FAIL bus_stable: tx_bus=%h was %h while busy", link.tx_bus, prev_bus);
            end
         end
         prev_busy = busy;
         prev_bus  = link.tx_bus;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic launch_word(input logic [BW-1:0] d);
      link.src_data  = d;
      link.src_valid = 1'b1;
      vectors++;
      if (link.src_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL launch_ready: src_ready=%b expected 1", link.src_ready);
      end
      tick;
      link.src_valid = 1'b0;
      model_bus = d;
      vectors++;
      if (link.tx_bus !== model_bus || busy !== 1'b1 || link.tx_req !== model_req) begin
         miscompares++;
         $display("FAIL accept: tx_bus=%h busy=%b tx_req=%b expected %h 1 %b",
                  link.tx_bus, busy, link.tx_req, model_bus, model_req);
      end
      tick;
      model_req = ~model_req;
      vectors++;
      if (link.tx_req !== model_req || link.tx_bus !== model_bus || link.src_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL req_flip: tx_req=%b tx_bus=%h src_ready=%b expected %b %h 0",
                  link.tx_req, link.tx_bus, link.src_ready, model_req, model_bus);
      end
   endtask

   // Destination model: after a delay, toggle ack; busy must drop NS+1 edges later.
   task automatic ack_and_complete(input int delay, input bit junk);
      for (int i = 0; i < delay; i++) begin
         if (junk) begin
            link.src_valid = 1'($urandom_range(0, 1));
            link.src_data  = BW'($urandom);
         end
         tick;
         vectors++;
         if (busy !== 1'b1 || link.src_ready !== 1'b0 || link.tx_bus !== model_bus) begin
            miscompares++;
            $display("FAIL wait_hold: busy=%b src_ready=%b tx_bus=%h expected 1 0 %h",
                     busy, link.src_ready, link.tx_bus, model_bus);
         end
      end
      if (junk) link.src_valid = 1'b0;
      model_ack = ~model_ack;
      link.ack_toggle = model_ack;
      for (int i = 0; i < NS; i++) begin
         tick;
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_latency: busy=%b expected 1 at %0d cycles after ack", busy, i + 1);
         end
      end
      tick;
      model_count = model_count + 1'b1;
      vectors++;
      if (busy !== 1'b0 || xfer_count !== model_count || link.src_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL complete: busy=%b xfer_count=%0d src_ready=%b expected 0 %0d 1",
                  busy, xfer_count, link.src_ready, model_count);
      end
   endtask

   task automatic apply_reset;
      rst = 1'b0;
      link.ack_toggle = 1'b0;
      link.src_valid  = 1'b0;
      model_req   = 1'b0;
      model_ack   = 1'b0;
      model_count = '0;
      model_bus   = '0;
      #1;
      vectors++;
      if (link.tx_bus !== '0 || link.tx_req !== 1'b0 || busy !== 1'b0 || xfer_count !== '0) begin
         miscompares++;
         $display("FAIL reset_state: tx_bus=%h tx_req=%b busy=%b xfer_count=%0d expected 0 0 0 0",
                  link.tx_bus, link.tx_req, busy, xfer_count);
      end
      @(negedge clk);
      rst = 1'b1;
      tick;
      vectors++;
      if (link.src_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: src_ready=%b busy=%b expected 1 0", link.src_ready, busy);
      end
   endtask

   task automatic test_reset;
      link.src_data   = '0;
      link.src_valid  = 1'b0;
      link.ack_toggle = 1'b0;
      #2;
      apply_reset;
   endtask

   task automatic test_single;
      launch_word(8'hA5);
      ack_and_complete(2, 1'b0);
   endtask

   task automatic test_back_to_back;
      link.src_data  = 8'h11;
      link.src_valid = 1'b1;
      tick;
      model_bus      = 8'h11;
      link.src_data  = 8'h22;
      vectors++;
      if (link.tx_bus !== 8'h11 || link.src_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_first: tx_bus=%h src_ready=%b expected 11 0", link.tx_bus, link.src_ready);
      end
      tick;
      model_req = ~model_req;
      ack_and_complete(3, 1'b0);
      tick;
      model_bus = 8'h22;
      link.src_valid = 1'b0;
      vectors++;
      if (link.tx_bus !== 8'h22 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_second: tx_bus=%h busy=%b expected 22 1", link.tx_bus, busy);
      end
      tick;
      model_req = ~model_req;
      vectors++;
      if (link.tx_req !== model_req) begin
         miscompares++;
         $display("FAIL bp_req: tx_req=%b expected %b", link.tx_req, model_req);
      end
      ack_and_complete(1, 1'b0);
   endtask

   task automatic test_spurious_ack;
      model_ack = ~model_ack;
      link.ack_toggle = model_ack;
      for (int i = 0; i < NS + 3; i++) begin
         tick;
         vectors++;
         if (busy !== 1'b0 || xfer_count !== model_count || link.tx_req !== model_req) begin
            miscompares++;
            $display("FAIL spurious: busy=%b xfer_count=%0d tx_req=%b expected 0 %0d %b",
                     busy, xfer_count, link.tx_req, model_count, model_req);
         end
      end
      model_ack = ~model_ack;
      link.ack_toggle = model_ack;
      repeat (NS + 2) tick;
      launch_word(BW'($urandom));
      ack_and_complete($urandom_range(0, 4), 1'b1);
   endtask

   task automatic test_reset_wait_ack;
      launch_word(8'h96);
      tick;
      apply_reset;
      launch_word(8'h3C);
      ack_and_complete(2, 1'b0);
   endtask

   task automatic test_wrap;
      apply_reset;
      for (int n = 0; n < 17; n++) begin
         repeat ($urandom_range(0, 3)) tick;
         launch_word(BW'($urandom));
         ack_and_complete($urandom_range(0, 5), 1'b1);
      end
      vectors++;
      if (xfer_count !== 4'd1) begin
         miscompares++;
         $display("FAIL wrap: xfer_count=%0d expected 1", xfer_count);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_spurious_ack;
      test_reset_wait_ack;
      test_wrap;
      repeat (2) tick;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
